// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR flip-flop bank driver.
// Holds the FSM state encoding, the per-bit excitation codes and the settle counter width helper.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    // Excitation codes are packed as {s, r}.
    localparam logic [1:0] EXC_HOLD = 2'b00;
    localparam logic [1:0] EXC_RST  = 2'b01;
    localparam logic [1:0] EXC_SET  = 2'b10;

    function automatic int settle_cnt_w(input int settle);
        return $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/sr_bank_driver_if.sv
// Request/acknowledge bus between control logic and the SR bank driver.
// The master side issues target words; the slave side reports completion and readback status.
interface sr_bank_driver_if #(
    parameter int WIDTH = 8
);
    logic             REQ;
    logic [WIDTH-1:0] TARGET;
    logic             BUSY;
    logic             ACK;
    logic             ERR;
    logic [WIDTH-1:0] MISMATCH;

    modport master (
        output REQ, TARGET,
        input  BUSY, ACK, ERR, MISMATCH
    );

    modport slave (
        input  REQ, TARGET,
        output BUSY, ACK, ERR, MISMATCH
    );
endinterface

// File: rtl/sr_excite.sv
// Per-bit SR excitation: drives the flop toward tgt from its current q, never S=R=1.
// An unknown q fails both comparisons and falls through to hold.
module sr_excite
    import sr_drv_pkg::*;
(
    input  logic tgt,
    input  logic q,
    output logic s,
    output logic r
);
    logic [1:0] exc;

    always_comb begin
        exc = EXC_HOLD;
        if (tgt == 1'b1 && q == 1'b0)
            exc = EXC_SET;
        else if (tgt == 1'b0 && q == 1'b1)
            exc = EXC_RST;
    end

    assign {s, r} = exc;
endmodule

// File: rtl/sr_bank_driver.sv
// Sequential driver for a bank of SR flip-flops: one-cycle S/R pulse, settle window, readback check.
// Transactions whose target already matches the bank skip straight to the readback.
module sr_bank_driver
    import sr_drv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic              CLK,
    input  logic              RST,
    sr_bank_driver_if.slave   bus,
    input  logic [WIDTH-1:0]  Q_FB,
    output logic [WIDTH-1:0]  S,
    output logic [WIDTH-1:0]  R
);
    localparam int               CW       = settle_cnt_w(SETTLE);
    localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);

    state_t           state;
    logic [WIDTH-1:0] tgt;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             ack_q;
    logic             err_q;
    logic [WIDTH-1:0] mis_q;
    logic [WIDTH-1:0] s_nx;
    logic [WIDTH-1:0] r_nx;
    logic             do_check;

    for (genvar i = 0; i < WIDTH; i++) begin : g_exc
        sr_excite u_exc (
            .tgt (bus.TARGET[i]),
            .q   (Q_FB[i]),
            .s   (s_nx[i]),
            .r   (r_nx[i])
        );
    end

    // Readback happens in the bypass CHECK cycle or on the last settle cycle, keeping latency at 1+SETTLE.
    assign do_check = (state == ST_CHECK) || (state == ST_SETTLE && cnt == CNT_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            tgt    <= '0;
            cnt    <= '0;
            S      <= '0;
            R      <= '0;
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            mis_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    S <= '0;
                    R <= '0;
                    if (bus.REQ) begin
                        tgt    <= bus.TARGET;
                        busy_q <= 1'b1;
                        if (|(s_nx | r_nx)) begin
                            S     <= s_nx;
                            R     <= r_nx;
                            state <= ST_DRIVE;
                        end else begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_DRIVE: begin
                    S     <= '0;
                    R     <= '0;
                    cnt   <= '0;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt != CNT_LAST)
                        cnt <= cnt + CW'(1);
                end
                ST_CHECK: ;
                default: state <= ST_IDLE;
            endcase

            if (do_check) begin
                mis_q  <= Q_FB ^ tgt;
                err_q  <= |(Q_FB ^ tgt);
                ack_q  <= 1'b1;
                busy_q <= 1'b0;
                state  <= ST_IDLE;
            end
        end
    end

    assign bus.BUSY     = busy_q;
    assign bus.ACK      = ack_q;
    assign bus.ERR      = err_q;
    assign bus.MISMATCH = mis_q;
endmodule

// File: doc/sr_bank_driver.md
# sr_bank_driver

Sequential driver for a bank of WIDTH positive-edge SR flip-flops. It accepts a target word over a REQ/ACK handshake and computes the per-bit S/R excitation from the bank's current Q. It pulses S/R for one cycle, waits a settle window, then reads the bank back and reports mismatches. It never issues the invalid S=R=1 combination; it sits between control logic and any SR-flop register bank.

## Interface
- WIDTH, 8, number of flip-flops in the bank (≥1)
- SETTLE, 2, idle cycles with S=R=0 between drive and readback (≥1)

- CLK  input  1  clock; all state updates on posedge
- RST  input  1  reset, asynchronous, active-high
- REQ  input  1  request; sampled only in IDLE
- TARGET  input  WIDTH  desired bank contents; captured with REQ
- Q_FB  input  WIDTH  Q outputs of the driven bank
- S  output  WIDTH  per-bit set lines to the bank (registered)
- R  output  WIDTH  per-bit reset lines to the bank (registered)
- BUSY  output  1  transaction in progress
- ACK  output  1  one-cycle completion pulse
- ERR  output  1  last readback differed from target; valid from ACK, held until next ACK
- MISMATCH  output  WIDTH  Q_FB XOR target at readback; held like ERR

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK.
- IDLE: S=R=0. On REQ=1, capture TARGET into tgt and compute excitation from the current Q_FB, per bit:
  - tgt=1, Q=0 gives S=1, R=0.
  - tgt=0, Q=1 gives S=0, R=1.
  - Otherwise S=R=0.
- Transitions out of IDLE:
  - If any S or R bit is set, load S/R and go to DRIVE.
  - Otherwise go straight to CHECK (bypass).
- DRIVE: lasts one cycle. Then clear S/R, zero the settle counter, and go to SETTLE.
- SETTLE: S=R=0. Count SETTLE cycles, then go to CHECK.
- CHECK: sample Q_FB and register MISMATCH = Q_FB ^ tgt and ERR = |MISMATCH. Pulse ACK, clear BUSY, return to IDLE.
- Invariant: (S & R) == 0 in every cycle, including reset.
- REQ while BUSY=1 is ignored, not queued. TARGET changes after capture have no effect.
- Q_FB bits that are X at excitation time drive S=R=0 for that bit. The readback then flags them as mismatches.
- RST at any point, including mid-DRIVE, asynchronously forces:
  - state IDLE;
  - S=0, R=0 (bank holds);
  - BUSY=0, ACK=0, ERR=0, MISMATCH=0;
  - tgt=0, counter=0.

## Timing
- Reset values: S=0, R=0, BUSY=0, ACK=0, ERR=0, MISMATCH=0.
- REQ accepted at edge k:
  - BUSY=1 from k.
  - Drive path: S/R high exactly between edges k and k+1. S=R=0 for edges k+1..k+1+SETTLE.
  - Drive path: Q_FB sampled at edge k+1+SETTLE; ACK high for the following cycle.
  - Drive-path latency is 1+SETTLE cycles to ACK (3 at default).
- Bypass path: Q_FB sampled at edge k+1; ACK in the following cycle. Latency is 1 cycle.
- BUSY falls at the same edge ACK rises. The FSM is in IDLE during the ACK cycle, so a REQ there is accepted (back-to-back throughput).
- ERR and MISMATCH update only at the ACK edge and otherwise hold.

## Structure
- Shared package sr_drv_pkg holds:
  - the state enum (IDLE, DRIVE, SETTLE, CHECK);
  - the excitation encoding constants (HOLD=2'b00, RST=2'b01, SET=2'b10);
  - a SETTLE counter width function, $clog2(SETTLE+1).
- One sub-module, sr_excite, is natural: a combinational per-bit excitation (tgt, q) to (s, r), replicated WIDTH times by generate.
- The top level holds the FSM, the tgt register, the settle counter and the output registers.

## Test plan
Bench defaults: WIDTH=8, SETTLE=2, and a behavioural bank of 8 SR flip-flops on CLK.
1. RST asserted mid-SETTLE -> S, R, BUSY, ACK, ERR and MISMATCH are 0 immediately (before the next edge); the bank holds its value; the next REQ is accepted normally.
2. Bank=8'h00, REQ with TARGET=8'hA5 -> S=8'hA5, R=8'h00 for one cycle; ACK 3 cycles after acceptance; bank=8'hA5, ERR=0, MISMATCH=8'h00.
3. Bank=8'hF0, TARGET=8'h3C -> S=8'h0C, R=8'hC0 in the drive cycle; S&R never nonzero; bank=8'h3C, ERR=0.
4. Bank=8'h5A, TARGET=8'h5A -> no S/R activity; ACK 1 cycle after acceptance; ERR=0.
5. Bank model with bit 3 stuck at 0, TARGET=8'hFF -> ACK with ERR=1, MISMATCH=8'h08; ERR stays 1 until the next ACK.
6. REQ held high continuously with TARGET alternating 8'h0F/8'hF0 -> a new transaction is accepted in each ACK cycle; REQ pulses during BUSY cause no extra ACKs.
